// File: rtl/xin_serializer_pkg.sv
// Shared definitions for the activation bit-plane serializer:
// FSM state encoding, default geometry and the bit-index width helper.
package xin_serializer_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    localparam int ROWS_DEF  = 64;
    localparam int XBITS_DEF = 4;

    // Width of the plane-weight index. Kept at least 1 bit wide.
    function automatic int bidx_w(input int xbits);
        return (xbits <= 2) ? 1 : $clog2(xbits);
    endfunction

endpackage

// File: rtl/xin_plane_sel.sv
// Combinational plane extractor: picks bit 'sel' of every row, applies the
// row mask, and reports which bit positions carry at least one set bit.
module xin_plane_sel #(
    parameter int ROWS  = 64,
    parameter int XBITS = 4,
    parameter int BW    = 2
) (
    input  logic [ROWS*XBITS-1:0] data,
    input  logic [ROWS-1:0]       mask,
    input  logic [BW-1:0]         sel,
    output logic [ROWS-1:0]       plane,
    output logic [XBITS-1:0]      nz
);

    // Masked bit-plane at the selected weight.
    always_comb begin
        plane = '0;
        for (int r = 0; r < ROWS; r++) begin
            plane[r] = data[r*XBITS + int'(sel)] & mask[r];
        end
    end

    // Per-weight non-zero flags of the masked vector (independent of sel,
    // so the look-ahead in the parent does not form a loop).
    always_comb begin
        nz = '0;
        for (int b = 0; b < XBITS; b++) begin
            for (int r = 0; r < ROWS; r++) begin
                nz[b] = nz[b] | (data[r*XBITS + b] & mask[r]);
            end
        end
    end

endmodule

// File: rtl/xin_serializer.sv
// Activation bit-plane serializer: captures a vector of XBITS-wide
// activations and drives it LSB-first, one masked bit-plane per accepted
// handshake, onto the read wordlines. Back-to-back vectors run without a
// bubble. Define XIN_SERIAL_SKIP_ZERO_EN to drop all-zero planes.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  S_IDLE  | no vector held, in_ready=1
//  S_DRIVE | presenting a plane, advancing on plane_ready
module xin_serializer
    import xin_serializer_pkg::*;
#(
    parameter int  ROWS  = ROWS_DEF,
    parameter int  XBITS = XBITS_DEF,
    localparam int BW    = bidx_w(XBITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS*XBITS-1:0] xin,
    input  logic [ROWS-1:0]       row_en,
    output logic [ROWS-1:0]       rwlb,
    output logic [BW-1:0]         bit_idx,
    output logic                  plane_valid,
    output logic                  plane_last,
    input  logic                  plane_ready,
    output logic                  busy
);

    state_t                 state;
    logic [ROWS*XBITS-1:0]  data_q;
    logic [ROWS-1:0]        mask_q;

    logic                   accept;
    logic                   load;
    logic                   adv;
    logic [ROWS*XBITS-1:0]  src_data;
    logic [ROWS-1:0]        src_mask;
    logic [ROWS-1:0]        sel_plane;
    logic [XBITS-1:0]       nz;
    logic [BW-1:0]          nxt_idx;
    logic                   nxt_last;
    int                     start_pos;

    assign accept   = plane_valid & plane_ready;
    assign in_ready = (state == S_IDLE) | (accept & plane_last);
    assign load     = in_valid & in_ready;
    assign adv      = accept & ~plane_last;
    assign busy     = (state == S_DRIVE);

    // On capture the first plane comes straight from the incoming vector.
    assign src_data = load ? xin    : data_q;
    assign src_mask = load ? row_en : mask_q;

    xin_plane_sel #(
        .ROWS  (ROWS),
        .XBITS (XBITS),
        .BW    (BW)
    ) u_plane_sel (
        .data  (src_data),
        .mask  (src_mask),
        .sel   (nxt_idx),
        .plane (sel_plane),
        .nz    (nz)
    );

`ifdef XIN_SERIAL_SKIP_ZERO_EN
    logic found;

    // Next plane is the lowest non-zero weight at or above the start point;
    // an all-zero vector still yields one plane at weight 0.
    always_comb begin
        start_pos = load ? 0 : int'(bit_idx) + 1;
        found     = 1'b0;
        nxt_idx   = '0;
        for (int i = 0; i < XBITS; i++) begin
            if (!found && i >= start_pos && nz[i]) begin
                nxt_idx = BW'(i);
                found   = 1'b1;
            end
        end
        nxt_last = 1'b1;
        for (int i = 0; i < XBITS; i++) begin
            if (found && i > int'(nxt_idx) && nz[i]) begin
                nxt_last = 1'b0;
            end
        end
    end
`else
    logic unused_nz;
    assign unused_nz = ^nz;

    // Every weight is emitted in order.
    always_comb begin
        start_pos = load ? 0 : int'(bit_idx) + 1;
        nxt_idx   = BW'(start_pos);
        nxt_last  = (start_pos == XBITS - 1);
    end
`endif

    // Control FSM with registered plane outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            data_q      <= '0;
            mask_q      <= '0;
            rwlb        <= '0;
            bit_idx     <= '0;
            plane_valid <= 1'b0;
            plane_last  <= 1'b0;
        end else if (load) begin
            state       <= S_DRIVE;
            data_q      <= xin;
            mask_q      <= row_en;
            rwlb        <= sel_plane;
            bit_idx     <= nxt_idx;
            plane_valid <= 1'b1;
            plane_last  <= nxt_last;
        end else if (adv) begin
            rwlb        <= sel_plane;
            bit_idx     <= nxt_idx;
            plane_last  <= nxt_last;
        end else if (accept) begin
            state       <= S_IDLE;
            data_q      <= '0;
            mask_q      <= '0;
            rwlb        <= '0;
            bit_idx     <= '0;
            plane_valid <= 1'b0;
            plane_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xin_serializer.sv
// Directed bench for xin_serializer (ROWS=4, XBITS=4) with a plane scoreboard.
module tb_xin_serializer;

    typedef struct {
        logic [3:0] rwlb;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] xin;
    logic [3:0]  row_en;
    logic [3:0]  rwlb;
    logic [1:0]  bit_idx;
    logic        plane_valid;
    logic        plane_last;
    logic        plane_ready;
    logic        busy;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   acc_cnt = 0;

    xin_serializer #(.ROWS(4), .XBITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .xin         (xin),
        .row_en      (row_en),
        .rwlb        (rwlb),
        .bit_idx     (bit_idx),
        .plane_valid (plane_valid),
        .plane_last  (plane_last),
        .plane_ready (plane_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model: expected planes for one captured vector.
    task automatic push_model(input logic [15:0] x, input logic [3:0] en);
        logic [3:0] p [4];
        exp_t       e;
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 4; r++)
                p[b][r] = x[r*4 + b] & en[r];
`ifdef XIN_SERIAL_SKIP_ZERO_EN
        begin
            int lastb;
            lastb = -1;
            for (int b = 0; b < 4; b++) if (p[b] != 4'd0) lastb = b;
            if (lastb < 0) begin
                e.rwlb = 4'd0; e.idx = 2'd0; e.last = 1'b1;
                sb.push_back(e);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (p[b] != 4'd0) begin
                        e.rwlb = p[b]; e.idx = 2'(b); e.last = (b == lastb);
                        sb.push_back(e);
                    end
                end
            end
        end
`else
        for (int b = 0; b < 4; b++) begin
            e.rwlb = p[b]; e.idx = 2'(b); e.last = (b == 3);
            sb.push_back(e);
        end
`endif
    endtask

    // Scoreboard: pop/compare accepted planes, push on vector capture.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (plane_valid && plane_ready) begin
                exp_t e;
                acc_cnt++;
                chk(32'(sb.size() > 0), 1, "sb_nonempty");
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk(rwlb, e.rwlb, "plane_rwlb");
                    chk(bit_idx, e.idx, "plane_idx");
                    chk(plane_last, e.last, "plane_last");
                end
            end else if (!plane_valid) begin
                chk(rwlb, 0, "idle_rwlb_zero");
                chk(bit_idx, 0, "idle_idx_zero");
            end
            if (in_valid && in_ready) push_model(xin, row_en);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 40 && busy; c++) step();
        chk(busy, 0, tag);
    endtask

    task automatic send(input logic [15:0] x, input logic [3:0] e);
        in_valid = 1'b1;
        xin      = x;
        row_en   = e;
        for (int c = 0; c < 40 && !in_ready; c++) step();
        chk(in_ready, 1, "send_ready");
        step();
        in_valid = 1'b0;
        drain("send_drain");
    endtask

    initial begin
        logic [3:0] held;
        int         a0;
        bit         seen;

        rst = 1'b1; in_valid = 1'b0; plane_ready = 1'b1; xin = '0; row_en = '0;
        #1;
        chk(plane_valid, 0, "rst_valid");
        chk(rwlb, 0, "rst_rwlb");
        chk(busy, 0, "rst_busy");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk(in_ready, 1, "rst_release_ready");

        // Basic vector, latency and last-plane handshake.
        in_valid = 1'b1; xin = 16'h0FA5; row_en = 4'hF;
        step();
        in_valid = 1'b0;
        chk(plane_valid, 1, "lat_first_valid");
        chk(bit_idx, 0, "lat_first_idx");
        chk(in_ready, 0, "drive_not_ready");
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            if (plane_last) begin
                seen = 1'b1;
                chk(c, 3, "last_cycle");
                chk(in_ready, 1, "ready_on_last");
            end else begin
                step();
            end
        end
        chk(seen, 1, "last_seen");
        step();
        chk(busy, 0, "idle_after_vec");

        // Row mask.
        send(16'h0FA5, 4'b0011);

        // Stall on bit_idx 1.
        in_valid = 1'b1; xin = 16'h3C96; row_en = 4'hF;
        step();
        in_valid = 1'b0;
        step();
        chk(bit_idx, 1, "stall_pre_idx");
        held = rwlb;
        plane_ready = 1'b0;
        repeat (3) begin
            step();
            chk(bit_idx, 1, "stall_idx");
            chk(rwlb, held, "stall_rwlb");
            chk(plane_valid, 1, "stall_valid");
        end
        plane_ready = 1'b1;
        drain("stall_drain");

        // Back-to-back vectors, no bubble.
        in_valid = 1'b1; xin = 16'hF0A5; row_en = 4'hF;
        step();
        xin = 16'h8421;
        for (int i = 0; i < 8; i++) begin
            chk(plane_valid, 1, "b2b_valid");
            chk(bit_idx, 32'(i % 4), "b2b_idx");
            if (i == 4) in_valid = 1'b0;
            step();
        end
        chk(busy, 0, "b2b_done");

        // Reset during bit_idx 2.
        in_valid = 1'b1; xin = 16'hFFFF; row_en = 4'hF;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk(bit_idx, 2, "rst_mid_idx_pre");
        rst = 1'b1;
        #1;
        chk(plane_valid, 0, "rst_mid_valid");
        chk(rwlb, 0, "rst_mid_rwlb");
        chk(bit_idx, 0, "rst_mid_idx");
        chk(plane_last, 0, "rst_mid_last");
        chk(busy, 0, "rst_mid_busy");
        step();
        step();
        rst = 1'b0;
        chk(in_ready, 1, "rst_mid_ready");
        in_valid = 1'b1; xin = 16'h0FA5; row_en = 4'hF;
        step();
        in_valid = 1'b0;
        chk(plane_valid, 1, "post_rst_valid");
        chk(bit_idx, 0, "post_rst_idx");
        drain("post_rst_drain");

        // Sparse and all-zero vectors.
        a0 = acc_cnt;
        send(16'h4444, 4'hF);
        step();
`ifdef XIN_SERIAL_SKIP_ZERO_EN
        chk(acc_cnt - a0, 1, "sparse_planes");
`else
        chk(acc_cnt - a0, 4, "sparse_planes");
`endif
        a0 = acc_cnt;
        send(16'h0000, 4'hF);
        step();
`ifdef XIN_SERIAL_SKIP_ZERO_EN
        chk(acc_cnt - a0, 1, "zero_planes");
`else
        chk(acc_cnt - a0, 4, "zero_planes");
`endif
        send(16'h5A3C, 4'b0000);
        send(16'h9E17, 4'b1010);

        step();
        chk(sb.size(), 0, "sb_drained");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
